// File: rtl/pwm_receiver_pkg.sv
// pwm_receiver_pkg: shared constants and helpers for the RC PWM receiver.
// Mirrors the motor encoder mapping: width_us = {rate,2'b00} + 1000.
package pwm_receiver_pkg;

   localparam int MOTOR_RATE_BIT_WIDTH = 8;
   localparam int RATE_W               = MOTOR_RATE_BIT_WIDTH;
   localparam int RC_PULSE_OFFSET_US   = 1000;
   localparam int MIN_ACCEPT_US        = 800;
   localparam int MAX_ACCEPT_US        = 2500;
   localparam int TIMEOUT_US           = 50000;
   localparam logic [RATE_W-1:0] FAILSAFE_RATE = 8'h00;

   localparam int WIDTH_W = 12;
   localparam int TMO_W   = 16;

   // rate = sat8((width - 1000) >> 2), clamped to 0 below the offset
   function automatic logic [RATE_W-1:0] width_to_rate(
      input logic [WIDTH_W-1:0] width
   );
      logic [WIDTH_W-1:0] diff;
      if (width <= WIDTH_W'(RC_PULSE_OFFSET_US)) begin
         return '0;
      end
      diff = (width - WIDTH_W'(RC_PULSE_OFFSET_US)) >> 2;
      if (diff > WIDTH_W'(255)) begin
         return '1;
      end
      return diff[RATE_W-1:0];
   endfunction

endpackage

// File: rtl/pwm_receiver_channel.sv
// pwm_receiver_channel: one PWM input lane.
// Synchronizer, pulse-width FSM, failsafe timeout and output registers.
module pwm_receiver_channel
   import pwm_receiver_pkg::*;
#(
   parameter int MIN_US = MIN_ACCEPT_US,
   parameter int MAX_US = MAX_ACCEPT_US,
   parameter int TMO_US = TIMEOUT_US,
   parameter logic [RATE_W-1:0] FS_RATE = FAILSAFE_RATE
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              pwm_i,
   output logic [RATE_W-1:0] rate_o,
   output logic              valid_o,
   output logic              update_o,
   output logic              err_o
);

   typedef enum logic [1:0] {
      ST_WAIT_LOW,
      ST_WAIT_RISE,
      ST_MEASURE
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         sync_q;
   logic [1:0]         prime_q;
   logic               s;
   logic [WIDTH_W-1:0] width_q, width_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [RATE_W-1:0]  rate_q, rate_d;
   logic               valid_q, valid_d;
   logic               upd_q, upd_d;
   logic               err_q, err_d;
   logic               at_max;
   logic               accept;
   logic               reject;

   assign s = sync_q[1];

   // Two-flop pin synchronizer; prime_q marks when s holds real pin
   // samples, so the reset zeros are not mistaken for a low level.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         prime_q <= '0;
      end else begin
         sync_q  <= {sync_q[0], pwm_i};
         prime_q <= {prime_q[0], 1'b1};
      end
   end

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_WAIT_LOW;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: wait for low, wait for rise, measure the high time
   always_comb begin
      state_d = state_q;
      if (!prime_q[1]) begin
         state_d = ST_WAIT_LOW;
      end else begin
         unique case (state_q)
            ST_WAIT_LOW: begin
               if (!s) state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
               if (s) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
               if (s && at_max) state_d = ST_WAIT_LOW;
               else if (!s)     state_d = ST_WAIT_RISE;
            end
            default: state_d = ST_WAIT_LOW;
         endcase
      end
   end

   // Outputs: width count, accept/reject decision, timeout and rate
   always_comb begin
      at_max  = (width_q == WIDTH_W'(MAX_US));
      accept  = (state_q == ST_MEASURE) && !s &&
                (width_q >= WIDTH_W'(MIN_US));
      reject  = (state_q == ST_MEASURE) &&
                ((s && at_max) ||
                 (!s && (width_q < WIDTH_W'(MIN_US))));
      width_d = width_q;
      if ((state_q == ST_WAIT_RISE) && s) begin
         width_d = WIDTH_W'(1);
      end else if ((state_q == ST_MEASURE) && s && !at_max) begin
         width_d = width_q + WIDTH_W'(1);
      end
      if (accept) begin
         tmo_d = '0;
      end else if (tmo_q == TMO_W'(TMO_US)) begin
         tmo_d = tmo_q;
      end else begin
         tmo_d = tmo_q + TMO_W'(1);
      end
      rate_d  = rate_q;
      valid_d = valid_q;
      if (accept) begin
         rate_d  = width_to_rate(width_q);
         valid_d = 1'b1;
      end else if (tmo_d == TMO_W'(TMO_US)) begin
         rate_d  = FS_RATE;
         valid_d = 1'b0;
      end
      upd_d = accept;
      err_d = reject;
   end

   // Datapath and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         width_q <= '0;
         tmo_q   <= '0;
         rate_q  <= '0;
         valid_q <= 1'b0;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         width_q <= width_d;
         tmo_q   <= tmo_d;
         rate_q  <= rate_d;
         valid_q <= valid_d;
         upd_q   <= upd_d;
         err_q   <= err_d;
      end
   end

   assign rate_o   = rate_q;
   assign valid_o  = valid_q;
   assign update_o = upd_q;
   assign err_o    = err_q;

endmodule

// File: rtl/pwm_receiver.sv
// pwm_receiver: RC servo-style PWM inputs to 8-bit rates.
// One independent channel instance per pin plus bus packing.
module pwm_receiver
   import pwm_receiver_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int MIN_US = MIN_ACCEPT_US,
   parameter int MAX_US = MAX_ACCEPT_US,
   parameter int TMO_US = TIMEOUT_US,
   parameter logic [RATE_W-1:0] FS_RATE = FAILSAFE_RATE
) (
   input  logic                     us_clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        pwm_in,
   output logic [NUM_CH*RATE_W-1:0] rate_out,
   output logic [NUM_CH-1:0]        rate_valid,
   output logic [NUM_CH-1:0]        rate_update,
   output logic [NUM_CH-1:0]        pulse_err
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pwm_receiver_channel #(
         .MIN_US  (MIN_US),
         .MAX_US  (MAX_US),
         .TMO_US  (TMO_US),
         .FS_RATE (FS_RATE)
      ) u_ch (
         .clk_i    (us_clk),
         .rst_i    (reset),
         .pwm_i    (pwm_in[i]),
         .rate_o   (rate_out[RATE_W*i +: RATE_W]),
         .valid_o  (rate_valid[i]),
         .update_o (rate_update[i]),
         .err_o    (pulse_err[i])
      );
   end

endmodule
